// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 video path: blitter FSM states,
// VRAM geometry and the byte-access code used on the memory video port.
package chip8_pkg;

    localparam int   VRAM_BYTES      = 256;
    localparam int   ROW_BYTES       = 8;
    localparam logic VIDEO_TYPE_BYTE = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD0_W,
        ST_WR0,
        ST_WR0_W,
        ST_RD1,
        ST_RD1_W,
        ST_WR1,
        ST_WR1_W,
        ST_CLR,
        ST_CLR_W,
        ST_DONE
    } blit_state_t;

endpackage

// File: rtl/chip8_sprite_align.sv
// Splits one 8-pixel sprite row at pixel position (x,y) into the two VRAM bytes it touches.
// CHIP8_SPRITE_WRAP_EN: the right-hand byte past the row end wraps to byte 0 of the same row.
module chip8_sprite_align #(
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 32
) (
    input  logic [7:0]  row,
    input  logic [5:0]  x,
    input  logic [4:0]  y,
    output logic [7:0]  mask0,
    output logic [7:0]  mask1,
    output logic [15:0] addr0,
    output logic [15:0] addr1,
    output logic        has1
);
    localparam int ROWB = SCREEN_W / 8;

    logic [5:0]  xm;
    logic [4:0]  ym;
    logic [2:0]  s;
    logic [15:0] b;
    logic [15:0] base;
    logic [15:0] spread;
    logic        last_byte;

    always_comb begin
        xm        = x & 6'(SCREEN_W - 1);
        ym        = y & 5'(SCREEN_H - 1);
        s         = xm[2:0];
        b         = 16'(xm[5:3]);
        base      = 16'(ym) * 16'(ROWB);
        // Upper byte is row>>s, lower byte is the spill row<<(8-s); spill is 0 when s==0.
        spread    = {row, 8'h00} >> s;
        mask0     = spread[15:8];
        mask1     = spread[7:0];
        addr0     = base + b;
        last_byte = (b == 16'(ROWB - 1));
        addr1     = last_byte ? base : addr0 + 16'd1;
`ifdef CHIP8_SPRITE_WRAP_EN
        has1      = (s != 3'd0);
`else
        has1      = (s != 3'd0) && !last_byte;
`endif
    end

endmodule

// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 framebuffer engine: sprite-row XOR and full-screen clear as byte read-modify-write
// on the memory video port, one request in flight. Edge wrap option: CHIP8_SPRITE_WRAP_EN.
module chip8_sprite_blitter
    import chip8_pkg::*;
#(
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic        cmd_clear_in,
    input  logic        cmd_first_in,
    input  logic [7:0]  cmd_row_in,
    input  logic [5:0]  cmd_x_in,
    input  logic [4:0]  cmd_y_in,
    output logic        done_out,
    output logic        collision_out,
    output logic [15:0] video_addr_out,
    output logic        video_we_out,
    output logic        video_valid_out,
    output logic [7:0]  video_data_out,
    output logic        video_type_out,
    input  logic        video_ready_in,
    input  logic        video_valid_in,
    input  logic [7:0]  video_data_in
);
    blit_state_t state;

    logic [7:0]  al_mask0, al_mask1;
    logic [15:0] al_addr0, al_addr1;
    logic        al_has1, al_use1;

    logic [7:0]  m0, m1;
    logic [15:0] a1;
    logic        h1;

    chip8_sprite_align #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_align (
        .row   (cmd_row_in),
        .x     (cmd_x_in),
        .y     (cmd_y_in),
        .mask0 (al_mask0),
        .mask1 (al_mask1),
        .addr0 (al_addr0),
        .addr1 (al_addr1),
        .has1  (al_has1)
    );

    // Second byte is only touched when it is on-screen (or wrapped) and has pixels.
    assign al_use1        = al_has1 && (al_mask1 != 8'h00);
    assign video_type_out = VIDEO_TYPE_BYTE;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            cmd_ready_out   <= 1'b1;
            done_out        <= 1'b0;
            collision_out   <= 1'b0;
            video_valid_out <= 1'b0;
            video_we_out    <= 1'b0;
            video_addr_out  <= 16'h0000;
            video_data_out  <= 8'h00;
            m0              <= 8'h00;
            m1              <= 8'h00;
            a1              <= 16'h0000;
            h1              <= 1'b0;
        end else begin
            case (state)
                // DONE behaves as IDLE so a command can be taken in the done cycle.
                ST_IDLE, ST_DONE: begin
                    done_out <= 1'b0;
                    state    <= ST_IDLE;
                    if (cmd_valid_in) begin
                        if (cmd_clear_in) begin
                            video_addr_out  <= 16'h0000;
                            video_data_out  <= 8'h00;
                            video_we_out    <= 1'b1;
                            video_valid_out <= 1'b1;
                            cmd_ready_out   <= 1'b0;
                            state           <= ST_CLR;
                        end else begin
                            if (cmd_first_in) collision_out <= 1'b0;
                            m0 <= al_mask0;
                            m1 <= al_mask1;
                            a1 <= al_addr1;
                            h1 <= al_use1;
                            if (al_mask0 != 8'h00) begin
                                video_addr_out  <= al_addr0;
                                video_we_out    <= 1'b0;
                                video_valid_out <= 1'b1;
                                cmd_ready_out   <= 1'b0;
                                state           <= ST_RD0;
                            end else if (al_use1) begin
                                video_addr_out  <= al_addr1;
                                video_we_out    <= 1'b0;
                                video_valid_out <= 1'b1;
                                cmd_ready_out   <= 1'b0;
                                state           <= ST_RD1;
                            end else begin
                                done_out <= 1'b1;
                                state    <= ST_DONE;
                            end
                        end
                    end
                end
                ST_RD0: if (video_ready_in) begin
                    video_valid_out <= 1'b0;
                    state           <= ST_RD0_W;
                end
                ST_RD0_W: if (video_valid_in) begin
                    video_data_out  <= video_data_in ^ m0;
                    collision_out   <= collision_out | (|(video_data_in & m0));
                    video_we_out    <= 1'b1;
                    video_valid_out <= 1'b1;
                    state           <= ST_WR0;
                end
                ST_WR0: if (video_ready_in) begin
                    video_valid_out <= 1'b0;
                    state           <= ST_WR0_W;
                end
                ST_WR0_W: if (video_valid_in) begin
                    if (h1) begin
                        video_addr_out  <= a1;
                        video_we_out    <= 1'b0;
                        video_valid_out <= 1'b1;
                        state           <= ST_RD1;
                    end else begin
                        video_we_out  <= 1'b0;
                        cmd_ready_out <= 1'b1;
                        done_out      <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_RD1: if (video_ready_in) begin
                    video_valid_out <= 1'b0;
                    state           <= ST_RD1_W;
                end
                ST_RD1_W: if (video_valid_in) begin
                    video_data_out  <= video_data_in ^ m1;
                    collision_out   <= collision_out | (|(video_data_in & m1));
                    video_we_out    <= 1'b1;
                    video_valid_out <= 1'b1;
                    state           <= ST_WR1;
                end
                ST_WR1: if (video_ready_in) begin
                    video_valid_out <= 1'b0;
                    state           <= ST_WR1_W;
                end
                ST_WR1_W: if (video_valid_in) begin
                    video_we_out  <= 1'b0;
                    cmd_ready_out <= 1'b1;
                    done_out      <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_CLR: if (video_ready_in) begin
                    video_valid_out <= 1'b0;
                    state           <= ST_CLR_W;
                end
                ST_CLR_W: if (video_valid_in) begin
                    if (video_addr_out == 16'(VRAM_BYTES - 1)) begin
                        video_we_out  <= 1'b0;
                        cmd_ready_out <= 1'b1;
                        done_out      <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        video_addr_out  <= video_addr_out + 16'd1;
                        video_valid_out <= 1'b1;
                        state           <= ST_CLR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Directed bench for chip8_sprite_blitter: byte-wide VRAM model with configurable ready/latency,
// hand-computed expected bytes, request order, collision and reset behaviour.
module tb_chip8_sprite_blitter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cmd_valid_in, cmd_ready_out, cmd_clear_in, cmd_first_in;
    logic [7:0]  cmd_row_in;
    logic [5:0]  cmd_x_in;
    logic [4:0]  cmd_y_in;
    logic        done_out, collision_out;
    logic [15:0] video_addr_out;
    logic        video_we_out, video_valid_out, video_type_out;
    logic [7:0]  video_data_out;
    logic        video_ready_in, video_valid_in;
    logic [7:0]  video_data_in;

    always #5 clk_in = ~clk_in;

    chip8_sprite_blitter dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_clear_in    (cmd_clear_in),
        .cmd_first_in    (cmd_first_in),
        .cmd_row_in      (cmd_row_in),
        .cmd_x_in        (cmd_x_in),
        .cmd_y_in        (cmd_y_in),
        .done_out        (done_out),
        .collision_out   (collision_out),
        .video_addr_out  (video_addr_out),
        .video_we_out    (video_we_out),
        .video_valid_out (video_valid_out),
        .video_data_out  (video_data_out),
        .video_type_out  (video_type_out),
        .video_ready_in  (video_ready_in),
        .video_valid_in  (video_valid_in),
        .video_data_in   (video_data_in)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // VRAM model: one request at a time, response pulse after a programmable delay.
    logic [7:0]  mem [256];
    logic [15:0] log_addr [$];
    logic        log_we   [$];
    bit          rnd_mode  = 1'b0;
    int          fixed_lat = 1;
    bit          busy      = 1'b0;
    int          cnt       = 0;
    logic [15:0] p_addr;
    logic        p_we;
    logic [7:0]  p_data;
    int          done_cnt  = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        video_ready_in = 1'b0;
        video_valid_in = 1'b0;
        video_data_in  = 8'h00;
        forever begin
            @(negedge clk_in);
            video_valid_in = 1'b0;
            if (busy) begin
                video_ready_in = 1'b0;
                if (cnt > 0) cnt--;
                else begin
                    if (p_we) mem[p_addr[7:0]] = p_data;
                    video_data_in  = p_we ? 8'h00 : mem[p_addr[7:0]];
                    video_valid_in = 1'b1;
                    busy           = 1'b0;
                end
            end else begin
                video_ready_in = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (video_valid_out && video_ready_in) begin
                    p_addr = video_addr_out;
                    p_we   = video_we_out;
                    p_data = video_data_out;
                    log_addr.push_back(video_addr_out);
                    log_we.push_back(video_we_out);
                    cnt  = rnd_mode ? int'($urandom_range(0, 3)) : fixed_lat;
                    busy = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (done_out === 1'b1) done_cnt++;
        end
    end

    task automatic send(input bit clr, input bit first, input logic [7:0] row,
                        input logic [5:0] x, input logic [4:0] y);
        @(negedge clk_in);
        cmd_valid_in = 1'b1;
        cmd_clear_in = clr;
        cmd_first_in = first;
        cmd_row_in   = row;
        cmd_x_in     = x;
        cmd_y_in     = y;
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
        cmd_clear_in = 1'b0;
        cmd_first_in = 1'b0;
    endtask

    task automatic blit(input string tag, input bit clr, input bit first, input logic [7:0] row,
                        input logic [5:0] x, input logic [4:0] y);
        int s;
        int k;
        log_addr.delete();
        log_we.delete();
        s = done_cnt;
        send(clr, first, row, x, y);
        k = 0;
        while (done_cnt == s && k < 10000) begin
            @(negedge clk_in);
            k++;
        end
        repeat (3) @(negedge clk_in);
        check({tag, "_done_once"}, done_cnt - s, 1);
        check({tag, "_ready"}, cmd_ready_out, 1'b1);
    endtask

    initial begin
        int bad;
        int s;
        int k;
        cmd_valid_in = 1'b0;
        cmd_clear_in = 1'b0;
        cmd_first_in = 1'b0;
        cmd_row_in   = 8'h00;
        cmd_x_in     = 6'd0;
        cmd_y_in     = 5'd0;
        rst_in       = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_ready", cmd_ready_out, 1'b1);
        check("rst_done", done_out, 1'b0);
        check("rst_coll", collision_out, 1'b0);
        check("rst_vvalid", video_valid_out, 1'b0);
        check("rst_we", video_we_out, 1'b0);
        check("rst_addr", video_addr_out, 16'h0000);
        check("rst_data", video_data_out, 8'h00);
        check("rst_type", video_type_out, 1'b0);
        rst_in = 1'b0;

        // Full row at origin on blank VRAM.
        blit("t1", 0, 1, 8'hFF, 6'd0, 5'd0);
        check("t1_byte0", mem[0], 8'hFF);
        check("t1_nreq", log_addr.size(), 2);
        check("t1_rd_addr", log_addr[0], 16'd0);
        check("t1_rd_we", log_we[0], 1'b0);
        check("t1_wr_we", log_we[1], 1'b1);
        check("t1_coll", collision_out, 1'b0);

        // Same row again without first: erases and collides.
        blit("t2", 0, 0, 8'hFF, 6'd0, 5'd0);
        check("t2_byte0", mem[0], 8'h00);
        check("t2_coll", collision_out, 1'b1);

        // Clear with random ready/latency; collision must survive.
        mem[5]   = 8'hAA;
        mem[200] = 8'h55;
        rnd_mode = 1'b1;
        blit("clr", 1, 1, 8'hFF, 6'd3, 5'd3);
        rnd_mode = 1'b0;
        check("clr_nreq", log_addr.size(), 256);
        bad = 0;
        foreach (log_addr[i]) if (log_addr[i] != 16'(i) || log_we[i] !== 1'b1) bad++;
        check("clr_order", bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 8'h00) bad++;
        check("clr_nonzero", bad, 0);
        check("clr_coll_kept", collision_out, 1'b1);

        // x=13 y=2: s=5 b=1 -> 0x07 @17, 0x80 @18.
        blit("t3", 0, 1, 8'hF0, 6'd13, 5'd2);
        check("t3_b17", mem[17], 8'h07);
        check("t3_b18", mem[18], 8'h80);
        check("t3_nreq", log_addr.size(), 4);
        check("t3_a0", log_addr[0], 16'd17);
        check("t3_a2", log_addr[2], 16'd18);
        check("t3_coll", collision_out, 1'b0);

        // Right screen edge, bottom row.
        blit("t4", 0, 1, 8'hFF, 6'd60, 5'd31);
        check("t4_b255", mem[255], 8'h0F);
`ifdef CHIP8_SPRITE_WRAP_EN
        check("t4_b248", mem[248], 8'hF0);
        check("t4_nreq", log_addr.size(), 4);
`else
        check("t4_b248", mem[248], 8'h00);
        check("t4_nreq", log_addr.size(), 2);
`endif

        // Empty row: no memory traffic.
        blit("zero", 0, 0, 8'h00, 6'd5, 5'd5);
        check("zero_nreq", log_addr.size(), 0);

        // Only the spill byte has pixels: byte 0 skipped.
        blit("spill", 0, 0, 8'h01, 6'd1, 5'd0);
        check("spill_b1", mem[1], 8'h80);
        check("spill_nreq", log_addr.size(), 2);
        check("spill_a0", log_addr[0], 16'd1);

        // Reset while waiting for the second-byte read.
        fixed_lat = 8;
        log_addr.delete();
        log_we.delete();
        send(0, 1, 8'hF0, 6'd13, 5'd2);
        k = 0;
        while (log_addr.size() < 3 && k < 500) begin
            @(negedge clk_in);
            k++;
        end
        check("t6_reach_rd1", log_addr.size() >= 3, 1'b1);
        repeat (2) @(negedge clk_in);
        check("t6_pre_coll", collision_out, 1'b1);
        s = done_cnt;
        rst_in = 1'b1;
        #1;
        check("t6_vvalid", video_valid_out, 1'b0);
        check("t6_ready", cmd_ready_out, 1'b1);
        check("t6_coll", collision_out, 1'b0);
        check("t6_we", video_we_out, 1'b0);
        check("t6_addr", video_addr_out, 16'h0000);
        @(negedge clk_in);
        rst_in = 1'b0;
        k = 0;
        while (busy && k < 500) begin
            @(negedge clk_in);
            k++;
        end
        repeat (3) @(negedge clk_in);
        check("t6_no_done", done_cnt - s, 0);
        check("t6_b17", mem[17], 8'h00);
        check("t6_b18", mem[18], 8'h80);
        fixed_lat = 1;

        blit("t6n", 0, 1, 8'h80, 6'd0, 5'd5);
        check("t6n_b40", mem[40], 8'h80);
        check("t6n_nreq", log_addr.size(), 2);
        check("t6n_coll", collision_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
